i2c_master_arbiter: RTL and testbench

- Shares one i2c_controller master between N_REQ requesters.
- Round-robin arbitration; grant held for a whole I2C transaction.
- Drives the master's addr/data_in/rw/enable, tracks its ready handshake and returns read data plus a completion pulse to the winner.
- Sits between client logic (sensor pollers, config sequencers) and the single shared master/SDA/SCL pair.

---
 rtl/i2c_master_arbiter.sv | 167 ++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master among N_REQ requesters.
// Grant is held for a full transaction: IDLE->ISSUE->WAIT_ACCEPT->WAIT_DONE->COMPLETE.
// Ports: clk, rst (async, active-low); req/req_addr/req_wdata/req_rw per requester;
//   grant/done/err per requester, rdata, busy; m_* master handshake (enable/addr/
//   data_in/rw out, ready/data_out in).
// Optional macro I2C_ARB_TIMEOUT_EN: abort-to-COMPLETE after TIMEOUT_CYC cycles
//   with err pulse and rdata=8'hFF; otherwise err is tied low.
module i2c_master_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  input  logic [N_REQ-1:0]   req_rw,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         rdata,
  output logic [N_REQ-1:0]   err,
  output logic               busy,
  output logic               m_enable,
  output logic [6:0]         m_addr,
  output logic [7:0]         m_data_in,
  output logic               m_rw,
  input  logic               m_ready,
  input  logic [7:0]         m_data_out
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_COMPLETE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] last_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick;
  logic          found;
  logic          win;
  logic          timeout;
  logic          tmo;

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] base,
    input int            k
  );
    int j;
    j = int'(base) + k;
    if (j >= N_REQ) j = j - N_REQ;
    return IW'(j);
  endfunction

  // First requester above last_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[rr_idx(last_ptr, k)]) begin
        found = 1'b1;
        pick  = rr_idx(last_ptr, k);
      end
    end
  end

  assign win = (state == S_IDLE) && found && m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:        if (win) state_nxt = S_ISSUE;
      S_ISSUE:       state_nxt = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: begin
        if (timeout)       state_nxt = S_COMPLETE;
        else if (!m_ready) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE:   if (m_ready || timeout) state_nxt = S_COMPLETE;
      S_COMPLETE:    state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant    = '0;
    done     = '0;
    err      = '0;
    busy     = 1'b0;
    m_enable = 1'b0;
    if (state != S_IDLE) begin
      busy         = 1'b1;
      grant[owner] = 1'b1;
    end
    if (state == S_ISSUE) m_enable = 1'b1;
    if (state == S_COMPLETE) begin
      done[owner] = 1'b1;
      err[owner]  = tmo;
    end
  end

  // Request fields are frozen at the arbitration win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ptr  <= IW'(N_REQ - 1);
      owner     <= '0;
      m_addr    <= '0;
      m_data_in <= '0;
      m_rw      <= 1'b0;
      rdata     <= '0;
    end else begin
      if (win) begin
        owner     <= pick;
        m_addr    <= req_addr[7*pick +: 7];
        m_data_in <= req_wdata[8*pick +: 8];
        m_rw      <= req_rw[pick];
      end
      if (state == S_WAIT_DONE && m_ready)
        rdata <= m_rw ? m_data_out : 8'h00;
      else if (timeout)
        rdata <= 8'hFF;
      if (state == S_COMPLETE) last_ptr <= owner;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;
  logic          waiting;

  // Counter is zero in ISSUE, so it equals cycles elapsed since ISSUE.
  // A master finishing on the limit cycle still completes normally.
  assign waiting = (state == S_WAIT_ACCEPT) ||
                   (state == S_WAIT_DONE && !m_ready);
  assign timeout = waiting && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      if (state == S_IDLE) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
      if (state == S_IDLE) tmo <= 1'b0;
      else if (timeout)    tmo <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign timeout    = 1'b0;
  assign tmo        = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed self-checking bench for i2c_master_arbiter (N_REQ=4, TIMEOUT_CYC=16)
// with a small behavioural master answering m_enable.
module tb_i2c_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_rw = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  rdata;
  logic [3:0]  err;
  logic        busy;
  logic        m_enable;
  logic [6:0]  m_addr;
  logic [7:0]  m_data_in;
  logic        m_rw;
  logic        m_ready;
  logic [7:0]  m_data_out;

  logic        mrdy;
  int          mcnt;
  logic        stuck = 1'b0;
  logic        hold_busy = 1'b0;
  logic [7:0]  mdata = '0;

  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  logic [6:0]  en_addr = '0;
  logic [7:0]  en_data = '0;
  logic        en_rw = 1'b0;
  logic        prev_en = 1'b0;
  logic        en_double = 1'b0;
  logic        multi_grant = 1'b0;
  logic        err_seen = 1'b0;
  int          done_cnt = 0;

  i2c_master_arbiter #(
    .N_REQ(4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_rw(req_rw),
    .grant(grant),
    .done(done),
    .rdata(rdata),
    .err(err),
    .busy(busy),
    .m_enable(m_enable),
    .m_addr(m_addr),
    .m_data_in(m_data_in),
    .m_rw(m_rw),
    .m_ready(m_ready),
    .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  assign m_ready    = mrdy & ~hold_busy;
  assign m_data_out = mdata;

  // Master model: drops ready after enable, raises it a few cycles later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mrdy <= 1'b1;
      mcnt <= 0;
    end else if (m_enable) begin
      mrdy <= 1'b0;
      mcnt <= 3;
    end else if (!mrdy && !stuck) begin
      if (mcnt <= 1) mrdy <= 1'b1;
      else           mcnt <= mcnt - 1;
    end
  end

  always @(posedge clk) begin
    prev_en <= m_enable;
    if (m_enable) begin
      en_cnt  <= en_cnt + 1;
      en_addr <= m_addr;
      en_data <= m_data_in;
      en_rw   <= m_rw;
    end
    if (m_enable && prev_en) en_double <= 1'b1;
  end

  always @(negedge clk) begin
    if ($countones(grant) > 1) multi_grant <= 1'b1;
    if (err != '0) err_seen <= 1'b1;
    if (done != '0) done_cnt <= done_cnt + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(
    output logic [3:0] d,
    output logic [7:0] r,
    output logic [3:0] e,
    output logic [3:0] g,
    output int         n
  );
    d = '0; r = '0; e = '0; g = '0; n = 0;
    while (d == '0 && n < 200) begin
      @(negedge clk);
      n++;
      if (done != '0) begin
        d = done; r = rdata; e = err; g = grant;
      end
    end
    if (d == '0) chk("wait_done_bound", n, 0);
  endtask

  initial begin
    logic [3:0] d, e, g;
    logic [7:0] r;
    int         n, e0, dc0;
    logic [3:0] exp_c [3];
    exp_c = '{4'b0001, 4'b0010, 4'b1000};

    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", m_enable, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_data_in, 0);
    chk("rst_rw", m_rw, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // single write
    req_addr[6:0]  = 7'h55;
    req_wdata[7:0] = 8'hAA;
    req_rw[0]      = 1'b0;
    e0  = en_cnt;
    req = 4'b0001;
    @(negedge clk);
    chk("wr_enable", m_enable, 1);
    chk("wr_grant", grant, 4'b0001);
    chk("wr_busy", busy, 1);
    chk("wr_maddr", m_addr, 7'h55);
    chk("wr_mdata", m_data_in, 8'hAA);
    chk("wr_mrw", m_rw, 0);
    wait_done(d, r, e, g, n);
    req[0] = 1'b0;
    chk("wr_done", d, 4'b0001);
    chk("wr_rdata", r, 8'h00);
    chk("wr_err", e, 0);
    @(negedge clk);
    chk("wr_pulse", done, 0);
    chk("wr_grant_clr", grant, 0);
    chk("wr_en_once", en_cnt - e0, 1);
    chk("wr_en_addr", en_addr, 7'h55);
    chk("wr_en_data", en_data, 8'hAA);

    // single read from requester 2
    req_addr[20:14] = 7'h3C;
    req_rw[2]       = 1'b1;
    mdata           = 8'h5A;
    req             = 4'b0100;
    @(negedge clk);
    chk("rd_grant0", grant, 4'b0100);
    wait_done(d, r, e, g, n);
    req[2] = 1'b0;
    chk("rd_done", d, 4'b0100);
    chk("rd_rdata", r, 8'h5A);
    chk("rd_grant", g, 4'b0100);
    chk("rd_en_rw", en_rw, 1);
    chk("rd_en_addr", en_addr, 7'h3C);

    // reset while in WAIT_DONE
    req_addr[6:0] = 7'h22;
    stuck = 1'b1;
    req   = 4'b0001;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_addr", m_addr, 7'h22);
    dc0 = done_cnt;
    rst = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_enable", m_enable, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", m_addr, 0);
    chk("arst_rdata", rdata, 0);
    req   = '0;
    stuck = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_no_done", done_cnt - dc0, 0);

    // contention 0,1,3
    req_rw = '0;
    req    = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      wait_done(d, r, e, g, n);
      req = req & ~d;
      chk("cont_order", d, exp_c[i]);
    end
    @(negedge clk);

    // fairness with 0 and 1 held
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_done(d, r, e, g, n);
      if (i == 3) req = '0;
      chk("fair_order", d, (i % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    @(negedge clk);

    // master busy at request
    req_rw[2] = 1'b1;
    hold_busy = 1'b1;
    e0  = en_cnt;
    req = 4'b0100;
    repeat (4) @(negedge clk);
    chk("mbusy_no_en", en_cnt - e0, 0);
    chk("mbusy_grant", grant, 0);
    chk("mbusy_busy", busy, 0);
    hold_busy = 1'b0;
    @(negedge clk);
    chk("mbusy_enable", m_enable, 1);
    wait_done(d, r, e, g, n);
    req = '0;
    chk("mbusy_done", d, 4'b0100);
    chk("mbusy_rdata", r, 8'h5A);
    @(negedge clk);

    // req dropped during WAIT_DONE
    req_rw[0] = 1'b0;
    req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("drop_busy", busy, 1);
    req = '0;
    wait_done(d, r, e, g, n);
    chk("drop_done", d, 4'b0001);
    @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
    stuck     = 1'b1;
    req_rw[3] = 1'b1;
    req       = 4'b1000;
    @(negedge clk);
    chk("tmo_enable", m_enable, 1);
    wait_done(d, r, e, g, n);
    req = '0;
    chk("tmo_done", d, 4'b1000);
    chk("tmo_err", e, 4'b1000);
    chk("tmo_rdata", r, 8'hFF);
    chk("tmo_cycles", n, 16);
    stuck = 1'b0;
    repeat (8) @(negedge clk);
`else
    chk("err_never", err_seen, 0);
`endif

    chk("onehot", multi_grant, 0);
    chk("en_single", en_double, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
